// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type, reset defaults and width helper for seq_detector_param
package seq_det_pkg;
    typedef enum logic [1:0] {HUNT = 2'd0, CMP = 2'd1, MATCH = 2'd2} state_t;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W = 8;
    localparam logic [DEF_MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011;
    localparam int DEF_LEN = 4;
    localparam logic DEF_OVERLAP = 1'b1;
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction
endpackage

// File: rtl/seq_hist_shreg.sv
// seq_hist_shreg: serial history shift register with saturating fill counter
module seq_hist_shreg import seq_det_pkg::*; #(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LW = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_x,
    input  logic               i_fill_clr,
    output logic [MAX_LEN-1:0] o_hist_next,
    output logic [LW-1:0]      o_fill,
    output logic [LW-1:0]      o_fill_next
);
    // The oldest bit is never compared again once shifted, so only MAX_LEN-1 bits are stored
    logic [MAX_LEN-2:0] r_hist;
    logic [LW-1:0]      r_fill;
    assign o_hist_next = {r_hist, i_x};
    assign o_fill      = r_fill;
    assign o_fill_next = (r_fill == LW'(MAX_LEN)) ? r_fill : r_fill + 1'b1;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_en) begin
            r_hist <= o_hist_next[MAX_LEN-2:0];
            r_fill <= i_fill_clr ? '0 : o_fill_next;
        end
    end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with saturating match counter
module seq_detector_param #(
    parameter int                 MAX_LEN     = seq_det_pkg::DEF_MAX_LEN,
    parameter int                 CNT_W       = seq_det_pkg::DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
    parameter int                 DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter logic               DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP,
    localparam int                LW          = seq_det_pkg::len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);
    import seq_det_pkg::*;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LW-1:0]      r_len;
    logic               r_overlap;
    state_t             r_state;
    state_t             w_state_next;
    logic               w_cfg_ok;
    logic               w_load;
    logic               w_bit;
    logic               w_match;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LW-1:0]      w_fill;
    logic [LW-1:0]      w_fill_next;
    assign w_cfg_ok = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
    assign w_load   = cfg_load && w_cfg_ok;
    // Any cfg_load, accepted or not, discards the bit offered in the same cycle
    assign w_bit    = en && !cfg_load;
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
        assign w_mask[i] = LW'(i) < r_len;
    end
    assign w_match = w_bit && (w_fill_next >= r_len) && (((w_hist_next ^ r_pattern) & w_mask) == '0);
    seq_hist_shreg #(.MAX_LEN(MAX_LEN), .LW(LW)) u_hist (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (w_load),
        .i_en       (w_bit),
        .i_x        (x),
        .i_fill_clr (w_match && !r_overlap),
        .o_hist_next(w_hist_next),
        .o_fill     (w_fill),
        .o_fill_next(w_fill_next)
    );
    always_comb begin
        w_state_next = w_load ? HUNT
                     : w_match ? MATCH
                     : w_bit ? ((w_fill_next >= r_len) ? CMP : HUNT)
                     : (r_state == MATCH) ? ((w_fill >= r_len) ? CMP : HUNT)
                     : r_state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= DEF_PATTERN;
            r_len     <= LW'(DEF_LEN);
            r_overlap <= DEF_OVERLAP;
            r_state   <= HUNT;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
            end
            r_state   <= w_state_next;
            cfg_err   <= cfg_load && !w_cfg_ok;
            match_cnt <= cnt_clr ? '0 : (w_match && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
        end
    end
    assign z = (r_state == MATCH);
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: vector table plus hand sequences, scoreboarded against two detector instances
module tb_seq_detector_param;
    logic       clk = 0, reset_n = 1, en = 0, x = 0, cfg_load = 0, cfg_overlap = 0, cnt_clr = 0;
    logic [7:0] cfg_pattern = 0;
    logic [3:0] cfg_len = 0;
    logic       z, z2, cfg_err, cfg_err2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    int         total = 0, bad = 0;

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic       en;
        logic       x;
        logic       clr;
        logic       ez;
        int         ec;
        logic       ee;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    seq_detector_param u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt), .cfg_err(cfg_err)
    );

    seq_detector_param #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .z(z2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
    );

    function automatic vec_t mk(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                                input logic ov, input logic e, input logic b, input logic clr,
                                input logic ez, input int ec, input logic ee);
        vec_t v;
        v.ld = ld; v.pat = pat; v.len = len; v.ov = ov; v.en = e; v.x = b; v.clr = clr;
        v.ez = ez; v.ec = ec; v.ee = ee;
        return v;
    endfunction

    function automatic vec_t bitv(input logic e, input logic b, input logic ez, input int ec);
        return mk(1'b0, 8'h00, 4'd0, 1'b0, e, b, 1'b0, ez, ec, 1'b0);
    endfunction

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        vec_t e;
        cfg_load = v.ld; cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ov;
        en = v.en; x = v.x; cnt_clr = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        cfg_load = 0; en = 0; cnt_clr = 0;
        e = exp_q.pop_front();
        check({nm, " z"}, int'(z), int'(e.ez));
        check({nm, " cnt"}, int'(match_cnt), e.ec);
        check({nm, " err"}, int'(cfg_err), int'(e.ee));
        check({nm, " z2"}, int'(z2), int'(e.ez));
        check({nm, " cnt2"}, int'(match_cnt2), (e.ec > 3) ? 3 : e.ec);
    endtask

    task automatic do_reset(input string nm);
        en = 0; cfg_load = 0; cnt_clr = 0;
        reset_n = 0;
        #2;
        check({nm, " rst z"}, int'(z), 0);
        check({nm, " rst cnt"}, int'(match_cnt), 0);
        check({nm, " rst err"}, int'(cfg_err), 0);
        check({nm, " rst cnt2"}, int'(match_cnt2), 0);
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    initial begin
        // defaults 1011 overlapping: stream 1011011
        tbl.push_back(bitv(1, 1, 0, 0));
        tbl.push_back(bitv(1, 0, 0, 0));
        tbl.push_back(bitv(1, 1, 0, 0));
        tbl.push_back(bitv(1, 1, 1, 1));
        tbl.push_back(bitv(1, 0, 0, 1));
        tbl.push_back(bitv(1, 1, 0, 1));
        tbl.push_back(bitv(1, 1, 1, 2));
        tbl.push_back(bitv(0, 0, 0, 2));
        // non-overlapping 1011, load-cycle bit discarded
        tbl.push_back(mk(1, 8'h0B, 4'd4, 0, 1, 1, 0, 0, 2, 0));
        tbl.push_back(bitv(1, 1, 0, 2));
        tbl.push_back(bitv(1, 0, 0, 2));
        tbl.push_back(bitv(1, 1, 0, 2));
        tbl.push_back(bitv(1, 1, 1, 3));
        tbl.push_back(bitv(1, 0, 0, 3));
        tbl.push_back(bitv(1, 1, 0, 3));
        tbl.push_back(bitv(1, 1, 0, 3));
        // full-length 11000011 with en gaps
        tbl.push_back(mk(1, 8'hC3, 4'd8, 1, 1, 0, 0, 0, 3, 0));
        tbl.push_back(bitv(1, 1, 0, 3));
        tbl.push_back(bitv(0, 0, 0, 3));
        tbl.push_back(bitv(1, 1, 0, 3));
        tbl.push_back(bitv(1, 0, 0, 3));
        tbl.push_back(bitv(0, 1, 0, 3));
        tbl.push_back(bitv(1, 0, 0, 3));
        tbl.push_back(bitv(1, 0, 0, 3));
        tbl.push_back(bitv(1, 0, 0, 3));
        tbl.push_back(bitv(0, 0, 0, 3));
        tbl.push_back(bitv(1, 1, 0, 3));
        tbl.push_back(bitv(1, 1, 1, 4));
        tbl.push_back(bitv(0, 1, 0, 4));

        do_reset("init");
        foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

        // rejected configs leave default 1011 in place
        do_reset("bad");
        run(mk(1, 8'h00, 4'd0, 1, 1, 1, 0, 0, 0, 1), "len0");
        run(mk(1, 8'hFF, 4'd9, 0, 1, 1, 0, 0, 0, 1), "len9");
        run(bitv(1, 1, 0, 0), "b0");
        run(bitv(1, 0, 0, 0), "b1");
        run(bitv(1, 1, 0, 0), "b2");
        run(bitv(1, 1, 1, 1), "b3");

        // reset in the middle of a partial pattern
        run(bitv(1, 1, 0, 1), "m0");
        run(bitv(1, 0, 0, 1), "m1");
        run(bitv(1, 1, 0, 1), "m2");
        do_reset("mid");
        run(bitv(1, 1, 0, 0), "m3");

        // six overlapping matches saturate the 2-bit counter; clear on the last match
        do_reset("sat");
        for (int i = 0; i < 19; i++) begin
            vec_t v;
            v = bitv(1, (i % 3 == 1) ? 1'b0 : 1'b1, (i >= 3 && i % 3 == 0) ? 1'b1 : 1'b0, (i == 18) ? 0 : i / 3);
            v.clr = (i == 18);
            run(v, $sformatf("s%0d", i));
        end
        run(bitv(0, 0, 0, 0), "s_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-sequence detector; the next generation of the team's fixed 4-bit Moore pattern detectors. Pattern, pattern length (1..MAX_LEN) and overlap mode are run-time programmable. A saturating match counter is included. Sits on any single-bit serial stream (framing/sync-word search) behind a valid-qualified bit input.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_1011: pattern after reset (LSB-aligned, MAX_LEN bits).
- DEF_LEN, 4: pattern length after reset.
- DEF_OVERLAP, 1: overlap mode after reset.
- Derived LW = $clog2(MAX_LEN+1).

- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  x is valid this cycle; no history update when low.
- x  in  1  serial data bit.
- cfg_load  in  1  one-cycle pulse: capture cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 = first bit received, bit 0 = last.
- cfg_len  in  LW  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  Moore match output, high one cycle per match.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  one-cycle pulse: rejected cfg_load.

## Operation
- History hist[MAX_LEN-1:0]: on en, hist <= {hist[MAX_LEN-2:0], x}; fill counter (0..MAX_LEN, saturating) increments.
- Match condition, evaluated on accepted bit: fill_next ≥ len and hist_next[len-1:0] == pattern[len-1:0] (upper bits masked).
- States: HUNT (fill < len, z=0), CMP (fill ≥ len, z=0), MATCH (z=1). Transitions on en bit: HUNT/CMP/MATCH → MATCH on match; otherwise → CMP if fill_next ≥ len, else HUNT. en low: MATCH → CMP (or HUNT after non-overlap clear); HUNT/CMP hold.
- Overlap=1: history kept after match. Overlap=0: fill cleared to 0 on the match bit; next match needs len fresh bits.
- cfg_load with 1 ≤ cfg_len ≤ MAX_LEN: capture config, clear fill and hist, go HUNT, z=0. Otherwise config unchanged, history unchanged, cfg_err=1 next cycle.
- match_cnt increments on every match, saturates at 2^CNT_W−1.
- Priorities: cfg_load beats en (x in that cycle discarded); cnt_clr beats a same-cycle increment (counter reads 0; z still asserts).

## Timing
- Reset (asynchronous, reset_n low): hist=0, fill=0, state HUNT, pattern/len/overlap = DEF_*, z=0, match_cnt=0, cfg_err=0. Release takes effect at the next clk edge.
- Latency: z high in the cycle after the edge that samples the completing bit (registered Moore output); match_cnt updates on that same edge.
- z high for exactly one cycle per match. Back-to-back matches (overlap, len=1, or repeating pattern) give a continuous z.
- New config active for the first en bit after the cfg_load edge.
- Reset asserted mid-stream discards partial history, returns counter to 0.

## Structure
- Package seq_det_pkg: state enum {HUNT, CMP, MATCH}; DEF_* constants; function computing LW.
- Sub-module seq_hist_shreg: history shift register plus saturating fill counter, with clear and enable. Top level holds config registers, compare, FSM and counter.

## Test plan
- Defaults (1011, len 4, overlap): after reset, drive 1,0,1,1,0,1,1 with en=1 → z pulses after bits 4 and 7; match_cnt=2.
- cfg_load 1011, overlap=0; same stream → one z pulse after bit 4; match_cnt=1.
- cfg_load pattern 8'b1100_0011, len 8; drive 11000011 with en gaps inserted → single z one cycle after 8th valid bit; no z for any 7-bit prefix.
- cfg_load len 0, then len 9 → cfg_err pulses each time; default 1011 detection still works.
- CNT_W=2: six matches → match_cnt stays 3; cnt_clr in a match cycle → match_cnt=0, z=1.
- reset_n low mid-pattern (after 101) → z=0, count 0; bit 1 alone after release gives no match.
